// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per request over a req/ack
// instruction-memory port, and resolves sequential/branch next-PC on load_pc.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       OFF_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              load_pc,
  input  logic [2:0]        branch_sel,
  input  logic [DATA_W-1:0] cond_val,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [3:0]        op_code,
  output logic              instr_valid,
  output logic              busy,
  output logic              branch_taken,
  output logic              fetch_err
);

  localparam int unsigned       CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DATA_W-1:0] NOP   = {4'hE, {(DATA_W-4){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d, pend_cond_q, pend_cond_d;
  logic [2:0]        pend_sel_q, pend_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d, req_q, req_d, busy_q, busy_d;
  logic              bt_q, bt_d, err_q, err_d, pend_q, pend_d;
  logic              defer_q, defer_d;

  logic              ld_apply, ld_taken, fetch_go;
  logic [2:0]        ld_sel;
  logic [DATA_W-1:0] ld_cond;
  logic [ADDR_W-1:0] off_ext;

  function automatic logic br_taken(input logic [2:0] sel, input logic [DATA_W-1:0] c);
    case (sel)
      3'b001:  br_taken = 1'b1;
      3'b010:  br_taken = c[DATA_W-1];
      3'b011:  br_taken = !c[DATA_W-1] && (c != '0);
      3'b100:  br_taken = (c == '0);
      default: br_taken = 1'b0;
    endcase
  endfunction

  assign off_ext = ADDR_W'($signed(instr_q[OFF_W-1:0]));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    req_d       = req_q;
    busy_d      = busy_q;
    bt_d        = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_sel_d  = pend_sel_q;
    pend_cond_d = pend_cond_q;
    defer_d     = 1'b0;
    ld_apply    = 1'b0;
    ld_taken    = 1'b0;
    fetch_go    = 1'b0;
    ld_sel      = branch_sel;
    ld_cond     = cond_val;

    case (state_q)
      S_IDLE: begin
        // A load pending from the BUSY period wins over a fresh load_pc this cycle.
        ld_apply = pend_q || load_pc;
        if (pend_q) begin
          ld_sel  = pend_sel_q;
          ld_cond = pend_cond_q;
        end
        pend_d = 1'b0;
        if (ld_apply) begin
          ld_taken = br_taken(ld_sel, ld_cond);
          pc_d     = ld_taken ? pc_q + off_ext : pc_q + ADDR_W'(1);
          bt_d     = ld_taken;
          valid_d  = 1'b0;
        end
        // A fetch coinciding with a PC update is issued a cycle later, from the new PC.
        fetch_go = fetch_start || defer_q;
        if (fetch_go && ld_apply) begin
          defer_d = 1'b1;
        end else if (fetch_go) begin
          state_d = S_BUSY;
          addr_d  = pc_q;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (load_pc) begin
          pend_d      = 1'b1;
          pend_sel_d  = branch_sel;
          pend_cond_d = cond_val;
        end
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
            req_d   = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            pend_d  = 1'b0;
            state_d = S_ERR;
          end
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      instr_q     <= NOP;
      valid_q     <= 1'b0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      bt_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_sel_q  <= '0;
      pend_cond_q <= '0;
      defer_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      bt_q        <= bt_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_sel_q  <= pend_sel_d;
      pend_cond_q <= pend_cond_d;
      defer_q     <= defer_d;
    end
  end

  assign pc           = pc_q;
  assign imem_addr    = addr_q;
  assign imem_req     = req_q;
  assign instr        = instr_q;
  assign op_code      = instr_q[DATA_W-1 -: 4];
  assign instr_valid  = valid_q;
  assign busy         = busy_q;
  assign branch_taken = bt_q;
  assign fetch_err    = err_q;

endmodule
